// File: rtl/ariane_pkg.sv
// Shared core types used by the multi-port branch unit: operators, predictions,
// resolutions and exceptions, plus the branch-unit additions bru_upd_t and BRU_MAX_PORTS.
package ariane_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned VLEN          = 32;
    localparam int unsigned BRU_MAX_PORTS = 4;

    localparam logic [XLEN-1:0] INSTR_ADDR_MISALIGNED = '0;

    typedef enum logic [3:0] {ADD, EQ, NE, LTS, LTU, GES, GEU, JALR} fu_op;
    typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;

    typedef struct packed {
        fu_op            operation;
        logic [XLEN-1:0] operand_a;
        logic [XLEN-1:0] imm;
    } fu_data_t;

    typedef struct packed {
        cf_t             cf;
        logic [VLEN-1:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
        logic            is_mispredict;
        logic            is_taken;
        cf_t             cf_type;
    } bp_resolve_t;

    typedef bp_resolve_t bru_upd_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic [XLEN-1:0] tval2;
        logic [XLEN-1:0] tinst;
        logic            gva;
        logic            valid;
    } exception_t;

    function automatic logic op_is_branch(input fu_op op);
        case (op)
            EQ, NE, LTS, LTU, GES, GEU: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_unit_mp_lane.sv
// Combinational per-port resolution: target, link value, mispredict and misaligned check.
// BRU_RVC_EN enables compressed link values and 2-byte target alignment.
module bru_resolve_lane
    import ariane_pkg::*;
(
    input  fu_data_t           i_fu_data,
    input  logic [VLEN-1:0]    i_pc,
    input  logic               i_is_compressed,
    input  logic               i_comp_res,
    input  branchpredict_sbe_t i_predict,
    input  logic               i_v,
    output logic [VLEN-1:0]    o_next_pc,
    output bp_resolve_t        o_res,
    output exception_t         o_ex
);

    logic            w_is_branch;
    logic [VLEN-1:0] w_base;
    logic [VLEN-1:0] w_target;
    logic            w_misaligned;

    assign w_is_branch = op_is_branch(i_fu_data.operation);
    assign w_base      = w_is_branch ? i_pc : i_fu_data.operand_a[VLEN-1:0];

    always_comb begin
        w_target = w_base + i_fu_data.imm[VLEN-1:0];
        if (!w_is_branch) w_target[0] = 1'b0;
    end

`ifdef BRU_RVC_EN
    assign o_next_pc    = i_pc + (i_is_compressed ? VLEN'(2) : VLEN'(4));
    assign w_misaligned = w_target[0];
`else
    logic w_unused_rvc;
    assign w_unused_rvc = i_is_compressed;
    assign o_next_pc    = i_pc + VLEN'(4);
    assign w_misaligned = |w_target[1:0];
`endif

    always_comb begin
        o_res       = '0;
        o_res.valid = 1'b1;
        o_res.pc    = i_pc;
        if (w_is_branch) begin
            o_res.is_taken      = i_comp_res;
            o_res.is_mispredict = i_comp_res != (i_predict.cf == Branch);
            o_res.cf_type       = Branch;
        end else begin
            o_res.is_taken      = 1'b1;
            o_res.is_mispredict = (i_predict.cf == NoCF) || (w_target != i_predict.predict_address);
            o_res.cf_type       = (i_predict.cf == Return) ? Return : JumpR;
        end
        o_res.target_address = o_res.is_taken ? w_target : o_next_pc;
    end

    always_comb begin
        o_ex       = '0;
        o_ex.cause = INSTR_ADDR_MISALIGNED;
        o_ex.tval  = XLEN'($signed(i_pc));
        o_ex.gva   = i_v;
        o_ex.valid = w_misaligned;
    end

endmodule

// File: rtl/branch_unit_mp.sv
// Multi-port branch resolution: oldest-fault cut, registered results and redirect,
// and a predictor-update FIFO with a saturating drop counter. Option macro: BRU_RVC_EN.
module branch_unit_mp
    import ariane_pkg::*;
#(
    parameter int unsigned NR_PORTS   = 2,
    parameter int unsigned UPD_DEPTH  = 4,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           v_i,
    input  logic [NR_PORTS-1:0]            valid_i,
    input  fu_data_t [NR_PORTS-1:0]        fu_data_i,
    input  logic [NR_PORTS-1:0][VLEN-1:0]  pc_i,
    input  logic [NR_PORTS-1:0]            is_compressed_i,
    input  logic [NR_PORTS-1:0]            comp_res_i,
    input  branchpredict_sbe_t [NR_PORTS-1:0] predict_i,
    output logic [NR_PORTS-1:0][VLEN-1:0]  result_o,
    output logic [NR_PORTS-1:0]            resolve_o,
    output exception_t [NR_PORTS-1:0]      exception_o,
    output bp_resolve_t                    redirect_o,
    output logic                           upd_valid_o,
    input  logic                           upd_ready_i,
    output bp_resolve_t                    upd_o,
    output logic [DROP_CNT_W-1:0]          drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(UPD_DEPTH);
    localparam int unsigned NW    = $clog2(NR_PORTS + UPD_DEPTH + 1);

    logic [NR_PORTS-1:0][VLEN-1:0] w_next_pc;
    bp_resolve_t [NR_PORTS-1:0]    w_res;
    exception_t [NR_PORTS-1:0]     w_ex;

    for (genvar g = 0; g < NR_PORTS; g++) begin : g_lane
        bru_resolve_lane u_lane (
            .i_fu_data       (fu_data_i[g]),
            .i_pc            (pc_i[g]),
            .i_is_compressed (is_compressed_i[g]),
            .i_comp_res      (comp_res_i[g]),
            .i_predict       (predict_i[g]),
            .i_v             (v_i),
            .o_next_pc       (w_next_pc[g]),
            .o_res           (w_res[g]),
            .o_ex            (w_ex[g])
        );
    end

    // Ports survive up to and including the oldest faulting one; the last survivor is the redirect.
    logic [NR_PORTS-1:0]        w_survive;
    logic                       w_cut;
    bp_resolve_t                w_redirect;
    bp_resolve_t [NR_PORTS-1:0] w_upd;
    exception_t [NR_PORTS-1:0]  w_ex_g;

    always_comb begin
        w_survive  = '0;
        w_cut      = 1'b0;
        w_redirect = '0;
        w_upd      = w_res;
        w_ex_g     = w_ex;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (valid_i[i] && !w_cut) begin
                w_survive[i] = 1'b1;
                w_redirect   = w_res[i];
                if (w_res[i].is_mispredict || w_ex[i].valid) w_cut = 1'b1;
            end
            w_upd[i].valid  = w_survive[i];
            w_ex_g[i].valid = w_ex[i].valid && w_survive[i];
        end
        w_redirect.valid         = |w_survive;
        w_redirect.is_mispredict = w_redirect.is_mispredict && (|w_survive);
    end

    logic [NR_PORTS-1:0][VLEN-1:0] r_result;
    logic [NR_PORTS-1:0]           r_resolve;
    exception_t [NR_PORTS-1:0]     r_ex;
    bp_resolve_t                   r_redirect;
    bp_resolve_t [NR_PORTS-1:0]    r_upd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || flush_i) begin
            r_result   <= '0;
            r_resolve  <= '0;
            r_ex       <= '0;
            r_redirect <= '0;
            r_upd      <= '0;
        end else begin
            r_result   <= w_next_pc;
            r_resolve  <= w_survive;
            r_ex       <= w_ex_g;
            r_redirect <= w_redirect;
            r_upd      <= w_upd;
        end
    end

    assign result_o    = r_result;
    assign resolve_o   = r_resolve;
    assign exception_o = r_ex;
    assign redirect_o  = r_redirect;

    // Update FIFO is fed from the stage register, so entries trail resolve_o by one cycle.
    bru_upd_t            r_mem [UPD_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [NW-1:0]       r_count;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                           w_pop;
    logic [NW-1:0]                  w_free;
    logic [NW-1:0]                  w_n_req;
    logic [NW-1:0]                  w_n_acc;
    logic [NW-1:0]                  w_drops;
    logic [NR_PORTS-1:0]            w_acc;
    logic [NR_PORTS-1:0][PTR_W-1:0] w_slot;
    logic [DROP_CNT_W:0]            w_drop_sum;

    assign upd_valid_o = (r_count != '0);
    assign upd_o       = r_mem[r_rd_ptr];
    assign w_pop       = upd_valid_o && upd_ready_i;
    assign w_free      = NW'(UPD_DEPTH) - r_count + NW'(w_pop);

    always_comb begin
        w_n_req = '0;
        w_n_acc = '0;
        w_acc   = '0;
        w_slot  = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            w_slot[i] = r_wr_ptr + PTR_W'(w_n_acc);
            if (r_resolve[i]) begin
                w_n_req = w_n_req + NW'(1);
                if (w_n_acc < w_free) begin
                    w_acc[i] = 1'b1;
                    w_n_acc  = w_n_acc + NW'(1);
                end
            end
        end
    end

    assign w_drops    = w_n_req - w_n_acc;
    assign w_drop_sum = (DROP_CNT_W+1)'(r_drop_cnt) + (DROP_CNT_W+1)'(w_drops);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int d = 0; d < UPD_DEPTH; d++) r_mem[d] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < NR_PORTS; i++)
                if (w_acc[i]) r_mem[w_slot[i]] <= r_upd[i];
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_acc);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + w_n_acc - NW'(w_pop);
        end
    end

    // Drop count survives flush; pending pushes discarded by a flush are not counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_drop_cnt <= '0;
        else if (!flush_i)
            r_drop_cnt <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
    end

    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_branch_unit_mp.sv
// Directed bench for branch_unit_mp: cut, redirect, alignment, FIFO back-pressure, flush, reset.
module tb_branch_unit_mp;
    import ariane_pkg::*;

    localparam int NR = 2;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic v = 1'b0;
    logic [NR-1:0] valid, comp, compr;
    fu_data_t [NR-1:0] fu;
    logic [NR-1:0][VLEN-1:0] pc, result;
    branchpredict_sbe_t [NR-1:0] pred;
    logic [NR-1:0] resolve;
    exception_t [NR-1:0] exc;
    bp_resolve_t redirect, upd;
    logic upd_valid, upd_ready;
    logic [DW-1:0] drop;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    branch_unit_mp #(.NR_PORTS(NR), .UPD_DEPTH(4), .DROP_CNT_W(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .v_i(v),
        .valid_i(valid), .fu_data_i(fu), .pc_i(pc), .is_compressed_i(compr),
        .comp_res_i(comp), .predict_i(pred), .result_o(result), .resolve_o(resolve),
        .exception_o(exc), .redirect_o(redirect), .upd_valid_o(upd_valid),
        .upd_ready_i(upd_ready), .upd_o(upd), .drop_cnt_o(drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = '0; comp = '0; compr = '0; fu = '0; pc = '0; pred = '0; v = 1'b0;
    endtask

    task automatic set_branch(input int p, input logic [31:0] a_pc, input logic [31:0] a_imm,
                              input logic a_cmp, input cf_t a_cf);
        valid[p] = 1'b1;
        fu[p].operation = EQ;
        fu[p].operand_a = '0;
        fu[p].imm = a_imm;
        pc[p] = a_pc;
        comp[p] = a_cmp;
        pred[p].cf = a_cf;
        pred[p].predict_address = '0;
    endtask

    task automatic set_jalr(input int p, input logic [31:0] a_pc, input logic [31:0] a_opa,
                            input logic [31:0] a_imm, input cf_t a_cf, input logic [31:0] a_pa);
        valid[p] = 1'b1;
        fu[p].operation = JALR;
        fu[p].operand_a = a_opa;
        fu[p].imm = a_imm;
        pc[p] = a_pc;
        comp[p] = 1'b0;
        pred[p].cf = a_cf;
        pred[p].predict_address = a_pa;
    endtask

    task automatic test_reset();
        idle();
        upd_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        total++; if (resolve !== 2'b00) begin bad++; $display("FAIL reset_resolve got=%b exp=00", resolve); end
        total++; if (redirect.valid !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", redirect.valid); end
        total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL reset_upd_valid got=%b exp=0", upd_valid); end
        total++; if (drop !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop); end
        total++; if (result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if (exc[0].valid !== 1'b0 || exc[1].valid !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b%b exp=00", exc[1].valid, exc[0].valid); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_beq();
        idle();
        set_branch(0, 32'h1000, 32'h40, 1'b1, NoCF);
        tick();
        idle();
        total++; if (redirect.valid !== 1'b1) begin bad++; $display("FAIL beq_redir_valid got=%b exp=1", redirect.valid); end
        total++; if (redirect.target_address !== 32'h1040) begin bad++; $display("FAIL beq_target got=%h exp=00001040", redirect.target_address); end
        total++; if (redirect.is_mispredict !== 1'b1) begin bad++; $display("FAIL beq_mispredict got=%b exp=1", redirect.is_mispredict); end
        total++; if (result[0] !== 32'h1004) begin bad++; $display("FAIL beq_result got=%h exp=00001004", result[0]); end
        total++; if (resolve !== 2'b01) begin bad++; $display("FAIL beq_resolve got=%b exp=01", resolve); end
        total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL beq_upd_early got=%b exp=0", upd_valid); end
        tick();
        total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL beq_upd_valid got=%b exp=1", upd_valid); end
        total++; if (upd.target_address !== 32'h1040) begin bad++; $display("FAIL beq_upd_target got=%h exp=00001040", upd.target_address); end
        tick();
        total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL beq_upd_single got=%b exp=0", upd_valid); end
    endtask

    task automatic test_cut();
        idle();
        set_jalr(0, 32'h800, 32'h3000, 32'h10, JumpR, 32'h4000);
        set_branch(1, 32'h1000, 32'h3, 1'b0, NoCF);
        tick();
        idle();
        total++; if (resolve !== 2'b01) begin bad++; $display("FAIL cut_resolve got=%b exp=01", resolve); end
        total++; if (exc[1].valid !== 1'b0) begin bad++; $display("FAIL cut_exc1 got=%b exp=0", exc[1].valid); end
        total++; if (redirect.target_address !== 32'h3010) begin bad++; $display("FAIL cut_target got=%h exp=00003010", redirect.target_address); end
        total++; if (redirect.is_mispredict !== 1'b1) begin bad++; $display("FAIL cut_mispredict got=%b exp=1", redirect.is_mispredict); end
        tick();
        total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL cut_upd_valid got=%b exp=1", upd_valid); end
        total++; if (upd.pc !== 32'h800) begin bad++; $display("FAIL cut_upd_pc got=%h exp=00000800", upd.pc); end
        tick();
        total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL cut_one_push got=%b exp=0", upd_valid); end
    endtask

    task automatic test_misaligned();
        idle();
        set_jalr(0, 32'h500, 32'h2001, 32'h0, JumpR, 32'h2000);
        tick();
        idle();
        total++; if (resolve !== 2'b01) begin bad++; $display("FAIL jalr_resolve got=%b exp=01", resolve); end
        total++; if (exc[0].valid !== 1'b0) begin bad++; $display("FAIL jalr_exc got=%b exp=0", exc[0].valid); end
        total++; if (redirect.target_address !== 32'h2000) begin bad++; $display("FAIL jalr_target got=%h exp=00002000", redirect.target_address); end
        total++; if (redirect.is_mispredict !== 1'b0) begin bad++; $display("FAIL jalr_mispredict got=%b exp=0", redirect.is_mispredict); end
        total++; if (result[0] !== 32'h504) begin bad++; $display("FAIL jalr_result got=%h exp=00000504", result[0]); end

        set_branch(0, 32'h1000, 32'h2, 1'b1, Branch);
        compr[0] = 1'b1;
        v = 1'b1;
        set_jalr(1, 32'h1002, 32'h3000, 32'h0, JumpR, 32'h3000);
        tick();
        idle();
`ifdef BRU_RVC_EN
        total++; if (exc[0].valid !== 1'b0) begin bad++; $display("FAIL mis_exc got=%b exp=0", exc[0].valid); end
        total++; if (resolve !== 2'b11) begin bad++; $display("FAIL mis_resolve got=%b exp=11", resolve); end
        total++; if (result[0] !== 32'h1002) begin bad++; $display("FAIL mis_result got=%h exp=00001002", result[0]); end
        total++; if (redirect.target_address !== 32'h3000) begin bad++; $display("FAIL mis_target got=%h exp=00003000", redirect.target_address); end
`else
        total++; if (exc[0].valid !== 1'b1) begin bad++; $display("FAIL mis_exc got=%b exp=1", exc[0].valid); end
        total++; if (exc[0].tval !== 32'h1000) begin bad++; $display("FAIL mis_tval got=%h exp=00001000", exc[0].tval); end
        total++; if (exc[0].cause !== INSTR_ADDR_MISALIGNED || exc[0].gva !== 1'b1) begin bad++; $display("FAIL mis_cause got=%h/%b exp=0/1", exc[0].cause, exc[0].gva); end
        total++; if (resolve !== 2'b01) begin bad++; $display("FAIL mis_resolve got=%b exp=01", resolve); end
        total++; if (result[0] !== 32'h1004) begin bad++; $display("FAIL mis_result got=%h exp=00001004", result[0]); end
        total++; if (redirect.target_address !== 32'h1002) begin bad++; $display("FAIL mis_target got=%h exp=00001002", redirect.target_address); end
`endif
        tick(); tick(); tick();
    endtask

    task automatic test_fifo_backpressure();
        idle();
        upd_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_branch(0, 32'h100 + 32'(8*n), 32'h20, 1'b0, NoCF);
            set_branch(1, 32'h104 + 32'(8*n), 32'h20, 1'b0, NoCF);
            tick();
        end
        idle();
        total++; if (drop !== 8'd0) begin bad++; $display("FAIL bp_full_nodrop got=%0d exp=0", drop); end
        tick();
        total++; if (drop !== 8'd2) begin bad++; $display("FAIL bp_drop got=%0d exp=2", drop); end
        total++; if (upd_valid !== 1'b1 || upd.pc !== 32'h100) begin bad++; $display("FAIL bp_head got=%b/%h exp=1/00000100", upd_valid, upd.pc); end
        tick();
        total++; if (upd.pc !== 32'h100) begin bad++; $display("FAIL bp_stable got=%h exp=00000100", upd.pc); end
        upd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (upd_valid !== 1'b1 || upd.pc !== 32'h100 + 32'(4*k)) begin bad++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", k, upd_valid, upd.pc, 32'h100 + 32'(4*k)); end
            tick();
        end
        total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", upd_valid); end
    endtask

    task automatic test_flush();
        idle();
        upd_ready = 1'b0;
        set_branch(0, 32'h200, 32'h20, 1'b0, NoCF);
        set_branch(1, 32'h204, 32'h20, 1'b0, NoCF);
        tick();
        idle();
        set_branch(0, 32'h208, 32'h20, 1'b0, NoCF);
        tick();
        idle();
        tick(); tick();
        total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL fl_pre got=%b exp=1", upd_valid); end
        set_branch(0, 32'h300, 32'h40, 1'b1, NoCF);
        set_branch(1, 32'h304, 32'h20, 1'b0, NoCF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        total++; if (resolve !== 2'b00) begin bad++; $display("FAIL fl_resolve got=%b exp=00", resolve); end
        total++; if (redirect.valid !== 1'b0) begin bad++; $display("FAIL fl_redirect got=%b exp=0", redirect.valid); end
        total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL fl_upd got=%b exp=0", upd_valid); end
        total++; if (drop !== 8'd2) begin bad++; $display("FAIL fl_drop got=%0d exp=2", drop); end
        tick();
        total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL fl_upd_after got=%b exp=0", upd_valid); end
        upd_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        idle();
        set_branch(0, 32'h1000, 32'h40, 1'b1, NoCF);
        set_branch(1, 32'h1004, 32'h40, 1'b1, NoCF);
        tick();
        tick();
        total++; if (resolve !== 2'b01) begin bad++; $display("FAIL ar_pre got=%b exp=01", resolve); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (resolve !== 2'b00 || redirect.valid !== 1'b0) begin bad++; $display("FAIL ar_stage got=%b/%b exp=00/0", resolve, redirect.valid); end
        total++; if (result !== 64'd0) begin bad++; $display("FAIL ar_result got=%h exp=0", result); end
        total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL ar_upd got=%b exp=0", upd_valid); end
        total++; if (drop !== 8'd0) begin bad++; $display("FAIL ar_drop got=%0d exp=0", drop); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        set_branch(0, 32'h1000, 32'h40, 1'b1, NoCF);
        tick();
        idle();
        total++; if (resolve !== 2'b01 || redirect.target_address !== 32'h1040) begin bad++; $display("FAIL ar_resume got=%b/%h exp=01/00001040", resolve, redirect.target_address); end
        tick();
        total++; if (upd_valid !== 1'b1 || upd.pc !== 32'h1000) begin bad++; $display("FAIL ar_resume_upd got=%b/%h exp=1/00001000", upd_valid, upd.pc); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_beq();
        test_cut();
        test_misaligned();
        test_fifo_backpressure();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
